// File: rtl/pipeline_stage_memory.sv
// pipeline_stage_memory: data-memory access stage with wait-state FSM, timeout abort and load/store lane steering.
// Optional MEM_ALIGN_CHECK_EN turns misaligned accesses into faulting bubbles instead of masking the low address bits.
package pipeline_stage_memory_pkg;
  typedef enum logic [1:0] {MEM_BYTE = 2'd0, MEM_HALF = 2'd1, MEM_WORD = 2'd2} mem_width_t;
  typedef logic [4:0] register_id_t;
  localparam register_id_t ZERO = 5'd0;
  typedef struct packed {
    logic memRead;
    logic memWrite;
    mem_width_t memWidth;
    logic memSignExtend;
    logic regWrite;
  } control_signals_t;
  typedef struct packed {
    logic [31:0] data1;
    logic [31:0] data2;
  } register_data_t;
  typedef struct packed {
    logic bubbled;
    logic [31:0] pc;
    control_signals_t signals;
    logic [31:0] aluResult;
    register_data_t regData;
    register_id_t regWriteId;
    logic [31:0] regDataWrite;
  } pipeline_result_execuation_t;
  typedef struct packed {
    logic bubbled;
    logic [31:0] pc;
    control_signals_t signals;
    logic [31:0] aluResult;
    register_data_t regData;
    register_id_t regWriteId;
    logic [31:0] regDataWrite;
    logic regDataWriteReady;
  } pipeline_result_memory_t;
  typedef struct packed {
    register_id_t registerId;
    logic dataReady;
    logic [31:0] data;
  } stage_register_data_t;
endpackage

module pipeline_stage_memory
  import pipeline_stage_memory_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  input  pipeline_result_execuation_t pipelineResultExecuation,
  output logic                        memReq,
  output logic                        memWrite,
  output logic [31:0]                 memAddr,
  output logic [3:0]                  memByteEnable,
  output logic [31:0]                 memWriteData,
  input  logic                        memReady,
  input  logic [31:0]                 memReadData,
  output pipeline_result_memory_t     pipelineResultMemory,
  output stage_register_data_t        resultOfInstructionAfterMemory,
  output logic                        stallOnMemory,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                        alignmentFault,
`endif
  output logic                        busFault
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, nextState;
  logic [CW-1:0] waitCount;
  pipeline_result_execuation_t ex;
  pipeline_result_memory_t captured;
  logic isByte, isHalf, misaligned, memOp, timeout;
  logic [1:0] offset;
  logic [31:0] laneData, loadData;
  assign ex = pipelineResultExecuation;
  assign isByte = ex.signals.memWidth == MEM_BYTE;
  assign isHalf = ex.signals.memWidth == MEM_HALF;
`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = !ex.bubbled && (ex.signals.memRead || ex.signals.memWrite) &&
                      (isHalf ? ex.aluResult[0] : !isByte && ex.aluResult[1:0] != 2'b00);
  assign offset = ex.aluResult[1:0];
`else
  assign misaligned = 1'b0;
  assign offset = isByte ? ex.aluResult[1:0] : isHalf ? {ex.aluResult[1], 1'b0} : 2'b00;
`endif
  assign memOp = !ex.bubbled && (ex.signals.memRead || ex.signals.memWrite) && !misaligned;
  // Completion wins over timeout when memReady lands on the abort cycle.
  assign timeout = TIMEOUT_CYCLES != 0 && state == WAIT && !memReady && waitCount == CW'(TIMEOUT_CYCLES);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      waitCount <= '0;
      busFault <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      alignmentFault <= 1'b0;
`endif
      pipelineResultMemory <= '0;
      pipelineResultMemory.bubbled <= 1'b1;
    end else begin
      state <= nextState;
      waitCount <= state == WAIT ? waitCount + 1'b1 : '0;
      busFault <= busFault | timeout;
`ifdef MEM_ALIGN_CHECK_EN
      alignmentFault <= alignmentFault | misaligned;
`endif
      if (stallOnMemory) pipelineResultMemory.bubbled <= 1'b1;
      else pipelineResultMemory <= captured;
    end
  always_comb
    nextState = state == IDLE ? (memOp && !memReady ? WAIT : IDLE) : (memReady || timeout ? IDLE : WAIT);
  always_comb begin
    memReq = !reset && ((state == IDLE && memOp) || state == WAIT);
    stallOnMemory = memReq && !memReady && !timeout;
    memWrite = ex.signals.memWrite;
    memAddr = {ex.aluResult[31:2], 2'b00};
    memByteEnable = isByte ? 4'b0001 << offset : isHalf ? 4'b0011 << offset : 4'b1111;
    memWriteData = isByte ? {4{ex.regData.data2[7:0]}} : isHalf ? {2{ex.regData.data2[15:0]}} : ex.regData.data2;
    laneData = memReadData >> {offset, 3'b000};
    loadData = isByte ? {{24{ex.signals.memSignExtend & laneData[7]}}, laneData[7:0]} :
               isHalf ? {{16{ex.signals.memSignExtend & laneData[15]}}, laneData[15:0]} : memReadData;
  end
  always_comb begin
    captured.bubbled = ex.bubbled | timeout | misaligned;
    captured.pc = ex.pc;
    captured.signals = ex.signals;
    captured.aluResult = ex.aluResult;
    captured.regData = ex.regData;
    captured.regWriteId = ex.regWriteId;
    captured.regDataWrite = ex.signals.memRead ? loadData : ex.regDataWrite;
    captured.regDataWriteReady = 1'b1;
  end
  always_comb begin
    resultOfInstructionAfterMemory.registerId = pipelineResultMemory.bubbled ? ZERO : pipelineResultMemory.regWriteId;
    resultOfInstructionAfterMemory.dataReady = pipelineResultMemory.bubbled | pipelineResultMemory.regDataWriteReady;
    resultOfInstructionAfterMemory.data = pipelineResultMemory.bubbled ? 32'd0 : pipelineResultMemory.regDataWrite;
  end
endmodule

// File: doc/pipeline_stage_memory.md
PIPELINE_STAGE_MEMORY -- requirements
Module: pipeline_stage_memory

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, maximum wait cycles for memReady before abort; 0 disables the timeout.
REQ-002 Port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: pipelineResultExecuation  input  pipeline_result_execuation_t  execution-stage output register.
REQ-005 Port: memReq  output  1  data-memory request valid.
REQ-006 Port: memWrite  output  1  1 = store, 0 = load; valid with memReq.
REQ-007 Port: memAddr  output  32  word-aligned byte address, i.e. {aluResult[31:2],2'b00}.
REQ-008 Port: memByteEnable  output  4  active byte lanes.
REQ-009 Port: memWriteData  output  32  store data shifted into the active lanes.
REQ-010 Port: memReady  input  1  memory completes the current request this cycle.
REQ-011 Port: memReadData  input  32  load word; valid when memReady=1.
REQ-012 Port: pipelineResultMemory  output  pipeline_result_memory_t  stage register feeding writeback.
REQ-013 Port: resultOfInstructionAfterMemory  output  stage_register_data_t  forwarding info.
REQ-014 Port: stallOnMemory  output  1  memory stage cannot accept; upstream stages hold.
REQ-015 Port: busFault  output  1  sticky; set on timeout abort.

Function
REQ-016 Memory operation = input not bubbled AND (signals.memRead OR signals.memWrite).
REQ-017 FSM states: IDLE, WAIT.
- IDLE -> WAIT when a memory operation is present and memReady=0.
- WAIT -> IDLE when memReady=1 or on timeout.
REQ-018 memReq = (IDLE AND memory operation) OR WAIT. Address, data and enables are driven combinationally from the input register and held stable while in WAIT.
REQ-019 stallOnMemory = memReq AND NOT memReady AND NOT timeout. Zero-wait memory (memReady in the request cycle) completes with no stall.
REQ-020 Byte lanes by signals.memWidth and aluResult[1:0]:
- byte: 1 << a[1:0]
- half: 4'b0011 << a[1:0]
- word: 4'b1111
REQ-021 Store data: regData.data2 replicated across lanes (byte x4, half x2).
REQ-022 Load data: the selected lane is extracted, then sign-extended if signals.memSignExtend, else zero-extended, to 32 bits.
REQ-023 When not stalled, the output register captures all input fields plus regDataWrite and regDataWriteReady=1:
- regDataWrite = load data if memRead;
- otherwise the incoming regDataWrite.
REQ-024 Output bubbled <= input bubbled OR stallOnMemory. All other output fields hold while stalled.
REQ-025 Latency: one clock from a completed access (or a non-memory instruction) to the output register.
REQ-026 Timeout counter: clears in IDLE and increments in WAIT. On reaching TIMEOUT_CYCLES:
- abort, return to IDLE, set busFault;
- the instruction passes as a bubble.
REQ-027 Forwarding output:
- if the output register is bubbled: registerId=ZERO, dataReady=1, data=0;
- otherwise: regWriteId, regDataWriteReady, regDataWrite from the output register.

Reset
REQ-028 Reset is asynchronous. While asserted, regardless of clock:
- FSM = IDLE, timeout counter = 0, busFault = 0, output bubbled = 1;
- memReq=0, stallOnMemory=0.
REQ-029 Reset asserted mid-WAIT abandons the request; memReady arriving after reset release is ignored in IDLE.

Configuration
REQ-030 Macro MEM_ALIGN_CHECK_EN.
- Defined: a half access with a[0]=1, or a word access with a[1:0]!=0, issues no memReq, sets sticky alignmentFault (extra 1-bit output port), and passes as a bubble.
- Undefined: no alignmentFault port; misaligned low bits are masked to the access size's natural alignment.

Verification
REQ-031 Load word at 0x100, memReady in the same cycle, memReadData=0xDEADBEEF -> no stall; next cycle regDataWrite=0xDEADBEEF and forward dataReady=1.
REQ-032 Signed load byte at 0x103, memReadData=0x80FFFFFF -> memByteEnable=4'b1000; result 0xFFFFFF80 (0x00000080 unsigned).
REQ-033 Store half 0x1234 at 0x202, memReady after 3 cycles -> stallOnMemory=1 for 3 cycles; memByteEnable=4'b1100, memWriteData=0x12341234; output bubbled for 3 cycles, then valid.
REQ-034 Load with memReady never asserted, TIMEOUT_CYCLES=4 -> abort after 4 WAIT cycles; busFault=1, stall released, instruction bubbled.
REQ-035 Reset asserted in WAIT -> memReq=0 and output bubbled=1 without a clock edge; a late memReady changes nothing.
REQ-036 With MEM_ALIGN_CHECK_EN, load word at 0x101 -> memReq never asserted, alignmentFault=1, output bubbled.
